// File: rtl/shift_right_serial.sv
// Serial right shifter: one bit per clock, logical or arithmetic fill,
// with a start/busy/done handshake and a result register updated only on completion.
module shift_right_serial #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;
  logic               mode;
  logic [WIDTH-1:0]   work_shr;

  // Fill bit is prepended and the whole vector shifted, so bit 0 drops off cleanly.
  always_comb begin
    work_shr = WIDTH'({mode & work[WIDTH-1], work} >> 1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      count    <= '0;
      mode     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            work  <= data_in;
            count <= shamt;
            mode  <= arith;
            if (shamt == '0) begin
              data_out <= data_in;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= work_shr;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            data_out <= work_shr;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_serial.sv
// Scoreboard bench for shift_right_serial: expected results queued at start,
// checked when done pulses; per-scenario tasks also check timing and holds.
module tb_shift_right_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [15:0] data_out;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_out = '0;

  shift_right_serial #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .arith    (arith),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s, input logic a);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) r = {a & r[15], r[15:1]};
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_pulse: unexpected done with data_out=%h, required no done", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL result: data_out=%h required %h", data_out, e);
        end
      end
    end
  end

  // Called and returns at a negedge; drives one operation and tracks it to completion.
  task automatic run_op(input logic [15:0] d, input logic [3:0] s, input logic a,
                        input logic [15:0] exp, input bit poke);
    int busy_cnt, done_cnt, done_idx;
    logic [15:0] hold;
    bit fin;
    hold = prev_out;
    data_in = d; shamt = s; arith = a; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0; data_in = ~d; shamt = ~s; arith = ~a;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; fin = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = k;
      end else if (busy) begin
        tests_run++;
        if (data_out !== hold) begin
          failures++;
          $display("FAIL hold: data_out=%h mid-operation, required %h", data_out, hold);
        end
      end
      if (!busy) begin
        fin = 1;
        start = 1'b0;
        break;
      end
      if (poke) begin
        start = 1'b1; data_in = 16'h1234; shamt = 4'd1; arith = 1'b0;
      end
    end
    start = 1'b0;
    tests_run++;
    if (!fin) begin
      failures++;
      $display("FAIL timeout: busy still high after 40 cycles, required low");
    end
    tests_run++;
    if (busy_cnt != int'(s) + 1) begin
      failures++;
      $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, int'(s) + 1);
    end
    tests_run++;
    if (done_cnt != 1 || done_idx != int'(s)) begin
      failures++;
      $display("FAIL done_timing: %0d pulses at cycle %0d, required 1 at cycle %0d", done_cnt, done_idx, s);
    end
    tests_run++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL held_result: data_out=%h after done, required %h", data_out, exp);
    end
    prev_out = exp;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; data_in = 16'hBEEF; shamt = 4'd3; arith = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b data_out=%h, required 0 0 0000", busy, done, data_out);
    end
    reset = 1'b0; start = 1'b0;
    prev_out = '0;
  endtask

  task automatic test_logical_max();
    run_op(16'h8000, 4'd15, 1'b0, 16'h0001, 0);
  endtask

  task automatic test_arith();
    run_op(16'h8000, 4'd15, 1'b1, 16'hFFFF, 0);
    run_op(16'h5554, 4'd1,  1'b1, 16'h2AAA, 0);
    run_op(16'h7FFF, 4'd15, 1'b1, 16'h0000, 0);
  endtask

  task automatic test_zero_shift();
    run_op(16'hAAAA, 4'd0, 1'b1, 16'hAAAA, 0);
  endtask

  task automatic test_busy_ignore();
    run_op(16'hFFFF, 4'd4, 1'b0, 16'h0FFF, 1);
  endtask

  task automatic test_back_to_back();
    run_op(16'h0002, 4'd1, 1'b0, 16'h0001, 0);
  endtask

  task automatic test_reset_abort();
    data_in = 16'hF0F0; shamt = 4'd8; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: busy=%b before reset, required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL abort: busy=%b done=%b data_out=%h, required 0 0 0000", busy, done, data_out);
    end
    reset = 1'b0;
    prev_out = '0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL abort_idle: busy=%b data_out=%h, required 0 0000", busy, data_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      logic [3:0]  s;
      logic        a;
      d = 16'($urandom);
      s = 4'($urandom_range(15));
      a = 1'($urandom_range(1));
      run_op(d, s, a, ref_shift(d, s, a), 0);
    end
  endtask

  initial begin
    test_reset();
    test_logical_max();
    test_arith();
    test_zero_shift();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d results never produced, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/shift_right_serial.md
Name: shift_right_serial

Overview:
Multi-cycle right shifter, the inverse-direction companion to the combinational left-shift-by-1 used for jump offsets. Shifts a 16-bit operand right by 0..15 bits, one bit per clock, logical (zero fill) or arithmetic (sign fill). Serves SRL/SRA-class instructions and recovers offsets from their shifted encoding. Uses a start/busy/done handshake with the control unit.

Parameters:
WIDTH, 16, operand and result width in bits
SHAMT_W, 4, shift-amount width; maximum shift is 2^SHAMT_W-1 (must be <= WIDTH-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
data_in  input  WIDTH  operand, captured with start
shamt  input  SHAMT_W  shift amount, captured with start
arith  input  1  1 = arithmetic (replicate MSB), 0 = logical (fill 0); captured with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
data_out  output  WIDTH  result register; holds its value until the next completed operation

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE, data_out=0, done=0, busy=0, internal work register and count cleared. Takes priority over every other input.
- States: IDLE, SHIFT, DONE. busy = (state != IDLE).
- IDLE: at an edge with start=1, latch work=data_in, count=shamt, mode=arith.
  - Next state is SHIFT if shamt != 0.
  - Next state is DONE if shamt == 0.
- SHIFT: each edge shifts work right by 1.
  - New MSB = work[WIDTH-1] if mode=1, else 0.
  - count decrements by 1.
  - When count goes 1->0, next state is DONE and the final shifted value is written to data_out on that same edge.
- shamt==0 path: data_out=data_in is written on the start edge.
- DONE: done=1 for exactly one cycle. Next edge returns to IDLE with done=0.
- Timing, with start sampled at edge E0 and n=shamt:
  - done is high during the cycle after edge En (n=0: the cycle after E0).
  - busy is high from after E0 until after E(n+1).
  - Total occupancy is n+1 cycles.
- start while busy=1, including the DONE cycle, is ignored. No queuing and no error.
- Back-to-back: start may be asserted in the cycle after done falls. It is sampled at the DONE->IDLE edge+1 (i.e. in IDLE).
- data_out updates only on completion. Intermediate shift values are never visible.
- data_in, shamt and arith may change freely after capture without affecting the operation in flight.
- Arithmetic right shift of a negative value never reaches 0. Maximum shift (15) gives 0xFFFF for a negative value and 0x0000 for a non-negative value.
- Reset mid-operation (SHIFT or DONE): abort, go to IDLE, data_out=0, and no done pulse.

Test Plan:
- Reset, then logical, data_in=16'h8000, shamt=15 -> done only in the cycle after E15; data_out=16'h0001; busy high 16 cycles.
- Arithmetic, data_in=16'h8000, shamt=15 -> data_out=16'hFFFF. Arithmetic, data_in=16'h5554, shamt=1 -> data_out=16'h2AAA (same as logical).
- shamt=0, data_in=16'hAAAA, arith=1 -> done in the cycle after E0; data_out=16'hAAAA; busy high 1 cycle.
- Logical, data_in=16'hFFFF, shamt=4 -> data_out=16'h0FFF at E4. A second start with 16'h1234/shamt=1 pulsed while busy is ignored. data_out stays 16'h0FFF after done and no second done occurs.
- Back-to-back: start in the first IDLE cycle after done, with 16'h0002/shamt=1 logical -> data_out=16'h0001 two cycles later; the previous data_out is held until then.
- Start 16'hF0F0, shamt=8, assert reset at E3 -> busy=0, done=0, data_out=16'h0000 after E3. No done pulse for the aborted operation.
